// File: rtl/dct_stream_pkg.sv
// +--------------------------------------------------------------------------+
// | Package     : dct_stream_pkg                                             |
// | Description : Shared lane/block constants and beat types for the DCT     |
// |               streaming path.                                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package dct_stream_pkg;

  localparam int LANES             = 4;
  localparam int DCT_BLOCK_SAMPLES = 64;
  localparam int DCT_DATA_WIDTH    = 8;
  localparam int DCT_OUT_WIDTH     = LANES * DCT_DATA_WIDTH;

  typedef struct packed {
    logic                     last;
    logic [DCT_OUT_WIDTH-1:0] data;
  } beat_t;

  // PH_A: waiting for the first pair of a beat; PH_B: first pair is staged.
  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// +--------------------------------------------------------------------------+
// | Module      : sync_fifo_fwft                                             |
// | Description : Single-clock first-word fall-through FIFO with occupancy.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module sync_fifo_fwft #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == (PTR_W+1)'(DEPTH));
  assign o_count = count_q;
  assign do_pop  = i_pop && !o_empty;
  // A pop on the same edge frees the slot the push lands in.
  assign do_push = i_push && (!o_full || do_pop);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  // Storage is not reset, so an empty FIFO presents zeros rather than stale data.
  assign o_data = o_empty ? '0 : mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/two_wide_axis_packer.sv
// +--------------------------------------------------------------------------+
// | Module      : two_wide_axis_packer                                       |
// | Description : Packs sample pairs into 4-lane AXIS beats with TLAST per   |
// |               block, buffered through a FWFT FIFO; drops on overflow.    |
// |               Optional PACKER_BLOCK_CNT_EN adds o_block_count.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module two_wide_axis_packer
  import dct_stream_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int BLOCK_SAMPLES = DCT_BLOCK_SAMPLES,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                      i_clk,
  input  logic                      i_resetn,
  input  logic [DATA_WIDTH-1:0]     i_data0,
  input  logic [DATA_WIDTH-1:0]     i_data1,
  input  logic                      i_valid,
  output logic [LANES*DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      o_overflow
`ifdef PACKER_BLOCK_CNT_EN
  ,
  output logic [15:0]               o_block_count
`endif
);

  localparam int OUT_WIDTH       = LANES * DATA_WIDTH;
  localparam int BEATS_PER_BLOCK = BLOCK_SAMPLES / LANES;
  localparam int CNT_W           = (BEATS_PER_BLOCK > 1) ? $clog2(BEATS_PER_BLOCK) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_BLOCK - 1);

  phase_e                  phase_q, phase_d;
  logic [2*DATA_WIDTH-1:0] stage_q, stage_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic                    overflow_q, overflow_d;
  logic                    beat_formed;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [OUT_WIDTH:0]      push_beat;
  logic [OUT_WIDTH:0]      head_beat;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      phase_q    <= PH_A;
      stage_q    <= '0;
      beat_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      stage_q    <= stage_d;
      beat_cnt_q <= beat_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    phase_d     = phase_q;
    stage_d     = stage_q;
    beat_cnt_d  = beat_cnt_q;
    overflow_d  = overflow_q;
    beat_formed = 1'b0;
    if (i_valid) begin
      case (phase_q)
        PH_A: begin
          stage_d = {i_data1, i_data0};
          phase_d = PH_B;
        end
        PH_B: begin
          beat_formed = 1'b1;
          phase_d     = PH_A;
          // Dropped beats still advance framing so TLAST stays block-aligned.
          beat_cnt_d  = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
          if (fifo_full && !fifo_pop) overflow_d = 1'b1;
        end
        default: phase_d = PH_A;
      endcase
    end
  end

  assign push_beat = {(beat_cnt_q == LAST_BEAT), i_data1, i_data0, stage_q};
  assign fifo_pop  = m_axis_tvalid && m_axis_tready;

  sync_fifo_fwft #(
    .WIDTH (OUT_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_push   (beat_formed),
    .i_data   (push_beat),
    .i_pop    (fifo_pop),
    .o_data   (head_beat),
    .o_full   (fifo_full),
    .o_empty  (fifo_empty),
    .o_count  (fifo_count_unused)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign {m_axis_tlast, m_axis_tdata} = head_beat;
  assign o_overflow    = overflow_q;

`ifdef PACKER_BLOCK_CNT_EN
  logic [15:0] block_cnt_q;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      block_cnt_q <= '0;
    end else if (fifo_pop && m_axis_tlast) begin
      block_cnt_q <= block_cnt_q + 16'd1;
    end
  end

  assign o_block_count = block_cnt_q;
`endif

endmodule

`default_nettype wire
